// File: rtl/axi_ic_pkg.sv
// Shared AXI interconnect constants: B-channel response codes and default ID geometry.
package axi_ic_pkg;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  localparam int ID_W_DEF  = 4;
  localparam int MST_W_DEF = 2;
  localparam int ERR_W_DEF = 8;

  // SLVERR and DECERR share bit 1; OKAY and EXOKAY have it clear.
  function automatic logic is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/wr_resp_arb_s4_if.sv
// Write-response bundle between four slave B channels and one master B channel.
interface wr_resp_arb_s4_if
  import axi_ic_pkg::*;
#(
  parameter int ID_W = ID_W_DEF
);
  logic [ID_W-1:0] bid_s1;
  logic [ID_W-1:0] bid_s2;
  logic [ID_W-1:0] bid_s3;
  logic [ID_W-1:0] bid_s4;
  logic [1:0]      bresp_s1;
  logic [1:0]      bresp_s2;
  logic [1:0]      bresp_s3;
  logic [1:0]      bresp_s4;
  logic            bvalid_s1;
  logic            bvalid_s2;
  logic            bvalid_s3;
  logic            bvalid_s4;
  logic            bready_s1;
  logic            bready_s2;
  logic            bready_s3;
  logic            bready_s4;
  logic [ID_W-1:0] bid_m;
  logic [1:0]      bresp_m;
  logic            bvalid_m;
  logic            bready_m;

  // Environment side: drives slave responses and master ready.
  modport master (
    output bid_s1, bid_s2, bid_s3, bid_s4,
    output bresp_s1, bresp_s2, bresp_s3, bresp_s4,
    output bvalid_s1, bvalid_s2, bvalid_s3, bvalid_s4,
    input  bready_s1, bready_s2, bready_s3, bready_s4,
    input  bid_m, bresp_m, bvalid_m,
    output bready_m
  );

  // Arbiter side.
  modport slave (
    input  bid_s1, bid_s2, bid_s3, bid_s4,
    input  bresp_s1, bresp_s2, bresp_s3, bresp_s4,
    input  bvalid_s1, bvalid_s2, bvalid_s3, bvalid_s4,
    output bready_s1, bready_s2, bready_s3, bready_s4,
    output bid_m, bresp_m, bvalid_m,
    input  bready_m
  );

endinterface

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin grant: search starts just after the last granted index.
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt
);

  logic [1:0] idx_s;
  logic       found_s;

  // First requester in order ptr+1, ptr+2, ptr+3, ptr wins.
  always_comb begin
    gnt     = 4'b0000;
    idx_s   = 2'd0;
    found_s = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx_s = ptr + 2'(k);
      if (!found_s && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/wr_resp_arb_s4.sv
// Fair B-channel arbiter for one master port: four slaves, round-robin, one registered output slot,
// saturating error-response counter.
module wr_resp_arb_s4
  import axi_ic_pkg::*;
#(
  parameter int ID_W  = ID_W_DEF,
  parameter int MST_W = MST_W_DEF,
  parameter int ERR_W = ERR_W_DEF
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [MST_W-1:0]     sel,
  wr_resp_arb_s4_if.slave      bus,
  output logic [ERR_W-1:0]     err_cnt
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [ID_W-1:0]  bid_a_s [4];
  logic [1:0]       bresp_a_s [4];
  logic [3:0]       bvalid_s;
  logic [3:0]       req_s;
  logic [3:0]       gnt_s;
  logic             acc_s;
  logic [1:0]       win_idx_s;
  logic [ID_W-1:0]  win_id_s;
  logic [1:0]       win_resp_s;

  logic [1:0]       ptr_r;
  logic [ID_W-1:0]  bid_m_r;
  logic [1:0]       bresp_m_r;
  logic             bvalid_m_r;
  logic [ERR_W-1:0] err_cnt_r;

  assign bid_a_s[0]   = bus.bid_s1;
  assign bid_a_s[1]   = bus.bid_s2;
  assign bid_a_s[2]   = bus.bid_s3;
  assign bid_a_s[3]   = bus.bid_s4;
  assign bresp_a_s[0] = bus.bresp_s1;
  assign bresp_a_s[1] = bus.bresp_s2;
  assign bresp_a_s[2] = bus.bresp_s3;
  assign bresp_a_s[3] = bus.bresp_s4;
  assign bvalid_s     = {bus.bvalid_s4, bus.bvalid_s3, bus.bvalid_s2, bus.bvalid_s1};

  // A slave only competes when its response is routed to this master.
  always_comb begin
    req_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      req_s[i] = bvalid_s[i] & (bid_a_s[i][ID_W-1 -: MST_W] == sel);
    end
  end

  rr_arb4 u_rr_arb4 (
    .req (req_s),
    .ptr (ptr_r),
    .gnt (gnt_s)
  );

  // Output slot can take a new response when empty or being drained this cycle.
  assign acc_s = (|req_s) & (~bvalid_m_r | bus.bready_m) & areset;

  assign bus.bready_s1 = gnt_s[0] & acc_s;
  assign bus.bready_s2 = gnt_s[1] & acc_s;
  assign bus.bready_s3 = gnt_s[2] & acc_s;
  assign bus.bready_s4 = gnt_s[3] & acc_s;

  // Winner payload selection from the one-hot grant.
  always_comb begin
    win_idx_s  = 2'd0;
    win_id_s   = '0;
    win_resp_s = 2'b00;
    case (gnt_s)
      4'b0001: win_idx_s = 2'd0;
      4'b0010: win_idx_s = 2'd1;
      4'b0100: win_idx_s = 2'd2;
      4'b1000: win_idx_s = 2'd3;
      default: win_idx_s = 2'd0;
    endcase
    win_id_s   = bid_a_s[win_idx_s];
    win_resp_s = bresp_a_s[win_idx_s];
  end

  // Output register, priority pointer and error counter.
  always_ff @(posedge aclk) begin
    if (!areset) begin
      ptr_r      <= 2'd3;
      bid_m_r    <= '0;
      bresp_m_r  <= 2'b00;
      bvalid_m_r <= 1'b0;
      err_cnt_r  <= '0;
    end else begin
      if (acc_s) begin
        bid_m_r    <= win_id_s;
        bresp_m_r  <= win_resp_s;
        bvalid_m_r <= 1'b1;
        ptr_r      <= win_idx_s;
      end else if (bvalid_m_r && bus.bready_m) begin
        bvalid_m_r <= 1'b0;
      end else begin
        bvalid_m_r <= bvalid_m_r;
      end
      if (bvalid_m_r && bus.bready_m && is_err(bresp_m_r) && (err_cnt_r != ERR_MAX)) begin
        err_cnt_r <= err_cnt_r + {{(ERR_W-1){1'b0}}, 1'b1};
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  assign bus.bid_m    = bid_m_r;
  assign bus.bresp_m  = bresp_m_r;
  assign bus.bvalid_m = bvalid_m_r;
  assign err_cnt      = err_cnt_r;

endmodule

// File: tb/tb_wr_resp_arb_s4.sv
// Directed bench for wr_resp_arb_s4: reset, rotation, ID filtering, backpressure, error counting, mid-flight reset.
module tb_wr_resp_arb_s4;
  import axi_ic_pkg::*;

  logic       aclk;
  logic       areset;
  logic [1:0] sel;
  logic [7:0] err_cnt;
  logic [3:0] brdy;
  int         total;
  int         bad;

  wr_resp_arb_s4_if #(.ID_W(4)) bus ();

  wr_resp_arb_s4 #(.ID_W(4), .MST_W(2), .ERR_W(8)) dut (
    .aclk    (aclk),
    .areset  (areset),
    .sel     (sel),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  assign brdy = {bus.bready_s4, bus.bready_s3, bus.bready_s2, bus.bready_s1};

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic slaves_idle();
    bus.bvalid_s1 = 1'b0; bus.bvalid_s2 = 1'b0; bus.bvalid_s3 = 1'b0; bus.bvalid_s4 = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    areset = 1'b0;
    sel    = 2'b01;
    bus.bready_m = 1'b0;
    bus.bid_s1 = 4'h4; bus.bid_s2 = 4'h5; bus.bid_s3 = 4'h6; bus.bid_s4 = 4'h7;
    bus.bresp_s1 = BRESP_OKAY; bus.bresp_s2 = BRESP_OKAY;
    bus.bresp_s3 = BRESP_OKAY; bus.bresp_s4 = BRESP_OKAY;
    slaves_idle();
    bus.bvalid_s1 = 1'b1;

    // 1: reset for 3 cycles with a matching request pending
    tick(); tick(); tick();
    chk("rst_bvalid", 32'(bus.bvalid_m), 32'd0);
    chk("rst_bid", 32'(bus.bid_m), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_bready", 32'(brdy), 32'd0);
    areset = 1'b1;
    slaves_idle();
    bus.bvalid_s3 = 1'b1; bus.bid_s3 = 4'b0110;
    bus.bready_m = 1'b1;
    #1;
    chk("t1_bready_s3", 32'(brdy), 32'b0100);
    tick();
    bus.bvalid_s3 = 1'b0;
    #1;
    chk("t1_bvalid", 32'(bus.bvalid_m), 32'd1);
    chk("t1_bid", 32'(bus.bid_m), 32'h6);

    // 2: short reset so s1 has priority, then all four slaves request
    areset = 1'b0;
    tick();
    areset = 1'b1;
    bus.bvalid_s1 = 1'b1; bus.bvalid_s2 = 1'b1; bus.bvalid_s3 = 1'b1; bus.bvalid_s4 = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("t2_gnt", 32'(brdy), 32'd1 << (k % 4));
      tick();
      chk("t2_bid", 32'(bus.bid_m), 32'(4 + (k % 4)));
      chk("t2_bvalid", 32'(bus.bvalid_m), 32'd1);
    end
    slaves_idle();

    // 3: s2 valid but its ID routes to another master
    bus.bvalid_s2 = 1'b1; bus.bid_s2 = 4'b1000;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t3_bready", 32'(brdy), 32'd0);
      chk("t3_bvalid", 32'(bus.bvalid_m), 32'd0);
    end
    slaves_idle();

    // 4: backpressure with s4 waiting, then back-to-back refill
    bus.bready_m = 1'b0;
    bus.bvalid_s2 = 1'b1; bus.bid_s2 = 4'h5;
    #1;
    chk("t4_load_s2", 32'(brdy), 32'b0010);
    tick();
    bus.bvalid_s2 = 1'b0;
    bus.bvalid_s4 = 1'b1; bus.bid_s4 = 4'h7;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_bready", 32'(brdy), 32'd0);
      chk("t4_hold_bid", 32'(bus.bid_m), 32'h5);
      chk("t4_hold_bvalid", 32'(bus.bvalid_m), 32'd1);
      tick();
    end
    bus.bready_m = 1'b1;
    #1;
    chk("t4_bready_s4", 32'(brdy), 32'b1000);
    tick();
    bus.bvalid_s4 = 1'b0;
    #1;
    chk("t4_refill_bid", 32'(bus.bid_m), 32'h7);
    chk("t4_refill_bvalid", 32'(bus.bvalid_m), 32'd1);
    tick();
    chk("t4_drain", 32'(bus.bvalid_m), 32'd0);

    // 5: 3 SLVERR + 2 OKAY, then 300 DECERR via s1
    bus.bid_s1 = 4'h4;
    bus.bvalid_s1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.bresp_s1 = (k < 3) ? BRESP_SLVERR : BRESP_OKAY;
      tick();
    end
    bus.bvalid_s1 = 1'b0;
    tick();
    chk("t5_err3", 32'(err_cnt), 32'd3);
    bus.bvalid_s1 = 1'b1;
    bus.bresp_s1 = BRESP_DECERR;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 200) chk("t5_err202", 32'(err_cnt), 32'd202);
      if (k == 253) chk("t5_err_sat", 32'(err_cnt), 32'd255);
    end
    bus.bvalid_s1 = 1'b0;
    tick();
    chk("t5_err_hold", 32'(err_cnt), 32'd255);

    // 6: reset while a response is held and ptr=2
    bus.bready_m = 1'b0;
    bus.bvalid_s3 = 1'b1; bus.bid_s3 = 4'h6;
    tick();
    chk("t6_pre_bvalid", 32'(bus.bvalid_m), 32'd1);
    areset = 1'b0;
    bus.bvalid_s1 = 1'b1; bus.bid_s1 = 4'h4; bus.bresp_s1 = BRESP_OKAY;
    #1;
    chk("t6_rst_bready", 32'(brdy), 32'd0);
    tick();
    chk("t6_rst_bvalid", 32'(bus.bvalid_m), 32'd0);
    chk("t6_rst_err", 32'(err_cnt), 32'd0);
    areset = 1'b1;
    bus.bready_m = 1'b1;
    #1;
    chk("t6_first_s1", 32'(brdy), 32'b0001);
    tick();
    chk("t6_bid", 32'(bus.bid_m), 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
